// File: rtl/apb_cmd_pkg.sv
// apb_cmd_pkg: command opcodes and FSM states shared by the APB command master
package apb_cmd_pkg;
  typedef enum logic [1:0] {
    OP_WR   = 2'b00,
    OP_RD   = 2'b01,
    OP_POLL = 2'b10,
    OP_RSV  = 2'b11
  } op_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_GAP,
    S_RESP
  } state_e;
endpackage

// File: rtl/apb_poll_timer.sv
// apb_poll_timer: inter-poll gap down-counter and saturating attempt counter
module apb_poll_timer #(
  parameter int CNT_W    = 16,
  parameter int POLL_GAP = 4
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             clr,
  input  logic             inc,
  input  logic             gap_load,
  input  logic [CNT_W-1:0] limit,
  output logic             limit_hit,
  output logic             gap_done
);
  localparam int GW = POLL_GAP > 1 ? $clog2(POLL_GAP) : 1;
  logic [CNT_W-1:0] attempts, nxt;
  logic [GW-1:0]    gap;
  // limit_hit looks at the count including the read completing this cycle
  assign nxt       = &attempts ? attempts : attempts + 1'b1;
  assign limit_hit = limit != '0 && nxt == limit;
  assign gap_done  = gap == '0;
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) begin
      attempts <= '0;
      gap      <= '0;
    end else begin
      attempts <= clr ? '0 : inc ? nxt : attempts;
      gap      <= gap_load ? GW'(POLL_GAP - 1) : gap_done ? gap : gap - 1'b1;
    end
endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: APB initiator executing write, read and masked-poll commands
module apb_cmd_master
  import apb_cmd_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int POLL_GAP = 4,
  parameter int CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [CNT_W-1:0]  cmd_limit,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);
  state_e           state;
  op_e              op_q;
  logic [DATA_W-1:0] mask_q;
  logic [CNT_W-1:0] limit_q;
  logic             xfer_done, poll_more, limit_hit, gap_done;
  op_e              op_in;
  assign op_in     = op_e'(cmd_op);
  assign xfer_done = state == S_ACCESS && PREADY;
  // a poll keeps going only on a clean read with no masked bit set
  assign poll_more = op_q == OP_POLL && !PSLVERR && (PRDATA & mask_q) == '0;
  apb_poll_timer #(.CNT_W(CNT_W), .POLL_GAP(POLL_GAP)) u_timer (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .clr      (cmd_valid && cmd_ready),
    .inc      (xfer_done && op_q == OP_POLL),
    .gap_load (xfer_done),
    .limit    (limit_q),
    .limit_hit(limit_hit),
    .gap_done (gap_done)
  );
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) begin
      state       <= S_IDLE;
      op_q        <= OP_WR;
      mask_q      <= '0;
      limit_q     <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PADDR       <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
    end else
      case (state)
        S_IDLE:
          if (cmd_valid) begin
            op_q        <= op_in;
            mask_q      <= cmd_wdata;
            limit_q     <= cmd_limit;
            cmd_ready   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            rsp_err     <= op_in == OP_RSV;
            if (op_in == OP_RSV) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
            end else begin
              state  <= S_SETUP;
              PSEL   <= 1'b1;
              PADDR  <= cmd_addr;
              PWRITE <= op_in == OP_WR;
              PWDATA <= op_in == OP_WR ? cmd_wdata : '0;
            end
          end
        S_SETUP: begin
          state   <= S_ACCESS;
          PENABLE <= 1'b1;
        end
        S_ACCESS:
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_rdata <= op_q == OP_WR ? '0 : PRDATA;
            rsp_err   <= PSLVERR;
            if (!poll_more || limit_hit) begin
              state       <= S_RESP;
              rsp_valid   <= 1'b1;
              rsp_timeout <= poll_more;
            end else
              state <= S_GAP;
          end
        S_GAP:
          if (gap_done) begin
            state <= S_SETUP;
            PSEL  <= 1'b1;
          end
        S_RESP:
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        default: state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: scoreboard bench for apb_cmd_master with a small APB slave model
module tb_apb_cmd_master;
  import apb_cmd_pkg::*;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;
  logic        CLK = 1'b0, RESETN = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0, rsp_rdata, PADDR, PWDATA, PRDATA;
  logic [15:0] cmd_limit = '0;
  logic        rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  int          vectors = 0, miscompares = 0, cyc = 0;
  exp_t        sb[$];
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .POLL_GAP(4), .CNT_W(16)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_limit(cmd_limit),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );
  // slave: ws wait states per access; in poll mode returns 1 from read number match_at on
  int          ws = 0, wcnt = 0, reads = 0, match_at = -1;
  bit          poll_mode = 1'b0, err_en = 1'b0;
  logic [31:0] rd_val = '0;
  assign PREADY  = PSEL && PENABLE && wcnt >= ws;
  assign PSLVERR = err_en && PREADY;
  assign PRDATA  = poll_mode ? ((match_at >= 0 && reads >= match_at) ? 32'h1 : 32'h0) : rd_val;
  always @(posedge CLK or negedge RESETN)
    if (!RESETN) wcnt <= 0;
    else if (PSEL && PENABLE) begin
      if (PREADY) begin
        wcnt  <= 0;
        reads <= reads + 1;
      end else wcnt <= wcnt + 1;
    end
  int          setup_t[$];
  logic [31:0] s_addr = '0, s_wd = '0;
  logic        s_wr = 1'b0;
  int          en_run = 0, last_en = 0, en_t = 0;
  always @(negedge CLK) begin
    if (PSEL && !PENABLE) begin
      setup_t.push_back(cyc);
      s_addr = PADDR; s_wr = PWRITE; s_wd = PWDATA; en_run = 0;
    end
    if (PSEL && PENABLE) begin
      if (en_run == 0) en_t = cyc;
      en_run++;
      vectors++;
      if ({PADDR, PWRITE, PWDATA} !== {s_addr, s_wr, s_wd}) begin
        miscompares++;
        $display("FAIL apb_stable: got %h/%b/%h want %h/%b/%h", PADDR, PWRITE, PWDATA, s_addr, s_wr, s_wd);
      end
      if (PREADY) last_en = en_run;
    end
    if (PENABLE && !PSEL) begin
      vectors++; miscompares++;
      $display("FAIL penable_no_psel: PENABLE=1 with PSEL=0 at cycle %0d", cyc);
    end
  end
  task automatic issue(input logic [1:0] op, input logic [31:0] a, d, input logic [15:0] lim, output int t0);
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_limit = lim;
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
    t0 = cyc;
  endtask
  task automatic wait_rsp(output int t);
    t = -1;
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK);
      if (rsp_valid) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      vectors++; miscompares++;
      $display("FAIL rsp_wait: no rsp_valid within 500 cycles");
    end
  endtask
  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge CLK);
    #1 rsp_ready = 1'b0;
  endtask
  task automatic test_reset();
    #12;
    vectors++;
    if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PADDR, PSEL, PENABLE, PWRITE, PWDATA} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_values: cmd_ready=%b rsp_valid=%b PSEL=%b PENABLE=%b PADDR=%h want 1/0/0/0/0", cmd_ready, rsp_valid, PSEL, PENABLE, PADDR);
    end
    @(negedge CLK) RESETN = 1'b1;
    repeat (2) @(negedge CLK);
  endtask
  task automatic test_write();
    int t0, t, n0;
    exp_t e;
    n0 = setup_t.size();
    issue(2'b00, 32'h0, 32'h1, 16'd0, t0);
    sb.push_back({32'h0, 1'b0, 1'b0});
    wait_rsp(t);
    vectors++;
    if (setup_t.size() != n0 + 1 || setup_t[n0] != t0) begin
      miscompares++;
      $display("FAIL wr_setup_time: got %0d setups, first at %0d, want 1 at %0d", setup_t.size() - n0, setup_t[n0], t0);
    end
    vectors++;
    if (en_t != t0 + 1) begin
      miscompares++;
      $display("FAIL wr_enable_time: got %0d want %0d", en_t, t0 + 1);
    end
    vectors++;
    if ({s_wr, s_wd, s_addr} !== {1'b1, 32'h1, 32'h0}) begin
      miscompares++;
      $display("FAIL wr_bus: got PWRITE=%b PWDATA=%h PADDR=%h want 1/00000001/00000000", s_wr, s_wd, s_addr);
    end
    vectors++;
    if (t != t0 + 2) begin
      miscompares++;
      $display("FAIL wr_latency: rsp_valid at %0d want %0d", t, t0 + 2);
    end
    e = sb.pop_front();
    vectors++;
    if ({rsp_rdata, rsp_err, rsp_timeout} !== e) begin
      miscompares++;
      $display("FAIL wr_rsp: got %h/%b/%b want %h/%b/%b", rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
    end
    ack();
    @(negedge CLK);
    vectors++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_return_idle: cmd_ready=%b rsp_valid=%b want 1/0", cmd_ready, rsp_valid);
    end
  endtask
  task automatic test_read_wait();
    int t0, t;
    exp_t e;
    ws = 3; rd_val = 32'h0000_1234;
    issue(2'b01, 32'h8, 32'hffff_ffff, 16'd0, t0);
    sb.push_back({32'h0000_1234, 1'b0, 1'b0});
    wait_rsp(t);
    vectors++;
    if (t != t0 + 5 || last_en != 4) begin
      miscompares++;
      $display("FAIL rd_wait_timing: rsp at %0d want %0d, PENABLE cycles %0d want 4", t, t0 + 5, last_en);
    end
    vectors++;
    if ({s_addr, s_wr, s_wd} !== {32'h8, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL rd_bus: got PADDR=%h PWRITE=%b PWDATA=%h want 00000008/0/00000000", s_addr, s_wr, s_wd);
    end
    e = sb.pop_front();
    vectors++;
    if ({rsp_rdata, rsp_err, rsp_timeout} !== e) begin
      miscompares++;
      $display("FAIL rd_rsp: got %h/%b/%b want %h/%b/%b", rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
    end
    ack();
    ws = 0;
  endtask
  task automatic test_poll_match();
    int t0, t, n0, r0;
    exp_t e;
    poll_mode = 1'b1; r0 = reads; match_at = reads + 3; n0 = setup_t.size();
    issue(2'b10, 32'h4, 32'h1, 16'd0, t0);
    sb.push_back({32'h1, 1'b0, 1'b0});
    wait_rsp(t);
    vectors++;
    if (reads - r0 != 4 || setup_t.size() - n0 != 4) begin
      miscompares++;
      $display("FAIL poll_match_reads: got %0d reads %0d setups want 4", reads - r0, setup_t.size() - n0);
    end
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if (setup_t[n0+i] - setup_t[n0+i-1] != 6) begin
        miscompares++;
        $display("FAIL poll_spacing: read %0d period %0d want 6", i, setup_t[n0+i] - setup_t[n0+i-1]);
      end
    end
    e = sb.pop_front();
    vectors++;
    if ({rsp_rdata, rsp_err, rsp_timeout} !== e) begin
      miscompares++;
      $display("FAIL poll_match_rsp: got %h/%b/%b want %h/%b/%b", rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
    end
    ack();
    poll_mode = 1'b0;
  endtask
  task automatic test_poll_timeout();
    int t0, t, r0;
    exp_t e;
    poll_mode = 1'b1; match_at = -1; r0 = reads;
    issue(2'b10, 32'h4, 32'h1, 16'd5, t0);
    sb.push_back({32'h0, 1'b0, 1'b1});
    wait_rsp(t);
    vectors++;
    if (reads - r0 != 5) begin
      miscompares++;
      $display("FAIL poll_timeout_reads: got %0d want 5", reads - r0);
    end
    e = sb.pop_front();
    vectors++;
    if ({rsp_rdata, rsp_err, rsp_timeout} !== e) begin
      miscompares++;
      $display("FAIL poll_timeout_rsp: got %h/%b/%b want %h/%b/%b", rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
    end
    ack();
    poll_mode = 1'b0;
  endtask
  task automatic test_slverr();
    int t0, t;
    exp_t e;
    err_en = 1'b1; rd_val = 32'hdead_beef;
    issue(2'b01, 32'h10, 32'h0, 16'd0, t0);
    sb.push_back({32'hdead_beef, 1'b1, 1'b0});
    wait_rsp(t);
    e = sb.pop_front();
    vectors++;
    if ({rsp_rdata, rsp_err, rsp_timeout} !== e) begin
      miscompares++;
      $display("FAIL slverr_rsp: got %h/%b/%b want %h/%b/%b", rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
    end
    ack();
    err_en = 1'b0;
  endtask
  task automatic test_reserved();
    int t0, t, n0;
    exp_t e;
    n0 = setup_t.size();
    issue(2'b11, 32'h20, 32'h5, 16'd0, t0);
    sb.push_back({32'h0, 1'b1, 1'b0});
    wait_rsp(t);
    vectors++;
    if (t != t0 || setup_t.size() != n0) begin
      miscompares++;
      $display("FAIL rsv_timing: rsp at %0d want %0d, bus setups %0d want 0", t, t0, setup_t.size() - n0);
    end
    e = sb.pop_front();
    vectors++;
    if ({rsp_rdata, rsp_err, rsp_timeout} !== e) begin
      miscompares++;
      $display("FAIL rsv_rsp: got %h/%b/%b want %h/%b/%b", rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
    end
    ack();
  endtask
  task automatic test_reset_mid();
    int t0;
    bit seen = 1'b0;
    poll_mode = 1'b1; match_at = -1;
    issue(2'b10, 32'h4, 32'h1, 16'd0, t0);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (PSEL && PENABLE) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL reset_mid_access: ACCESS not reached within 50 cycles");
    end
    #2 RESETN = 1'b0;
    #1;
    vectors++;
    if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_async: PSEL/PENABLE/rsp_valid/cmd_ready=%b%b%b%b want 0001", PSEL, PENABLE, rsp_valid, cmd_ready);
    end
    @(negedge CLK) RESETN = 1'b1;
    repeat (3) @(negedge CLK);
    vectors++;
    if ({PSEL, rsp_valid, cmd_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_release: PSEL/rsp_valid/cmd_ready=%b%b%b want 001", PSEL, rsp_valid, cmd_ready);
    end
    poll_mode = 1'b0;
  endtask
  task automatic test_back_to_back();
    int t0, t, n0;
    exp_t e;
    rd_val = 32'h0000_abcd;
    issue(2'b01, 32'hc, 32'h0, 16'd0, t0);
    sb.push_back({32'h0000_abcd, 1'b0, 1'b0});
    wait_rsp(t);
    n0 = setup_t.size();
    repeat (10) begin
      @(negedge CLK);
      vectors++;
      if ({rsp_valid, rsp_rdata, PSEL, cmd_ready} !== {1'b1, 32'h0000_abcd, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL rsp_hold: rsp_valid=%b rdata=%h PSEL=%b cmd_ready=%b want 1/0000abcd/0/0", rsp_valid, rsp_rdata, PSEL, cmd_ready);
      end
    end
    vectors++;
    if (setup_t.size() != n0) begin
      miscompares++;
      $display("FAIL rsp_hold_bus: %0d bus cycles during hold want 0", setup_t.size() - n0);
    end
    e = sb.pop_front();
    vectors++;
    if ({rsp_rdata, rsp_err, rsp_timeout} !== e) begin
      miscompares++;
      $display("FAIL hold_rsp: got %h/%b/%b want %h/%b/%b", rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
    end
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 32'h0; cmd_wdata = 32'h2;
    ack();
    @(negedge CLK);
    vectors++;
    if (cmd_ready !== 1'b1 || PSEL !== 1'b0) begin
      miscompares++;
      $display("FAIL no_accept_at_handshake: cmd_ready=%b PSEL=%b want 1/0", cmd_ready, PSEL);
    end
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
    t0 = cyc;
    sb.push_back({32'h0, 1'b0, 1'b0});
    wait_rsp(t);
    vectors++;
    if (t != t0 + 2 || s_wd !== 32'h2) begin
      miscompares++;
      $display("FAIL b2b_write: rsp at %0d want %0d, PWDATA %h want 00000002", t, t0 + 2, s_wd);
    end
    e = sb.pop_front();
    vectors++;
    if ({rsp_rdata, rsp_err, rsp_timeout} !== e) begin
      miscompares++;
      $display("FAIL b2b_rsp: got %h/%b/%b want %h/%b/%b", rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
    end
    ack();
  endtask
  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_poll_match();
    test_poll_timeout();
    test_slverr();
    test_reserved();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
APB initiator that drives the APB slave port of the accelerator tops (pool/conv) from a simple command/response interface.
- Used by the host-side sequencer and by block benches to program the start register and read back status and the clock counter.
- Executes single writes, single reads, and a hardware poll loop: repeated reads until a masked bit is set or an attempt limit is hit.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
POLL_GAP, 4, idle cycles (PSEL=0) between poll reads; minimum 1
CNT_W, 16, width of the poll attempt counter and of cmd_limit

Ports:
CLK  in  1  clock
RESETN  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_op  in  2  00 write, 01 read, 10 poll, 11 reserved
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data (write op); bit mask (poll op)
cmd_limit  in  CNT_W  maximum poll reads; 0 means unlimited
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  last PRDATA captured (0 for write and reserved ops)
rsp_err  out  1  PSLVERR seen, or reserved op
rsp_timeout  out  1  poll hit cmd_limit without a match
PADDR  out  ADDR_W  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Clocking and reset: single clock CLK; RESETN is asynchronous, active-low.
- Reset values: all outputs 0 except cmd_ready=1. Internal state=IDLE, counters 0.
- Reset asserted mid-transfer drops PSEL/PENABLE immediately. The command is lost and no response is issued.
- All outputs are registered.
- States: IDLE, SETUP, ACCESS, GAP, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch op/addr/wdata/limit and clear the attempt counter.
  - op 11 -> RESP with rsp_err=1, no bus activity.
  - Otherwise -> SETUP.
- SETUP (1 cycle):
  - PSEL=1, PENABLE=0, PADDR=addr.
  - PWRITE=1 only for a write op.
  - PWDATA=wdata for a write op, else 0.
  - Then -> ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; hold while PREADY=0. No internal wait timeout.
  - On PREADY=1: capture PRDATA into rsp_rdata (reads and polls), or 0 for writes; capture PSLVERR.
  - Next cycle PSEL=PENABLE=0.
- Transitions out of ACCESS:
  - write/read -> RESP.
  - poll: attempt counter increments on each completed read, then:
    - PSLVERR=1 -> RESP, rsp_err=1. Checked first.
    - else (PRDATA & mask)!=0 -> RESP. Match takes priority over timeout on the same read.
    - else limit!=0 and attempts==limit -> RESP, rsp_timeout=1.
    - else -> GAP.
- GAP: PSEL=0 for POLL_GAP cycles, then -> SETUP (same addr).
- RESP:
  - rsp_valid=1; rsp_rdata, rsp_err and rsp_timeout are stable until rsp_ready.
  - On rsp_valid&&rsp_ready, the next cycle returns to IDLE with rsp_valid=0 and cmd_ready=1.
  - A new command cannot be accepted in the same cycle as the response handshake.
- Latency: accept at edge N -> SETUP N+1 -> ACCESS N+2. With PREADY=1, rsp_valid rises at N+3.
- Poll read period with PREADY=1 is POLL_GAP+2 cycles.
- APB rules:
  - PADDR, PWRITE and PWDATA are stable from SETUP through ACCESS completion.
  - PENABLE is never high without PSEL.
  - PADDR, PWRITE and PWDATA hold their last values while idle.
- Attempt counter saturates at all-ones when limit=0. The unlimited poll continues until match or error.

Decomposition:
- Package apb_cmd_pkg: op encodings (OP_WR, OP_RD, OP_POLL, OP_RSV) and the state enum.
- Sub-module apb_poll_timer: GAP down-counter plus attempt counter, with limit compare and saturation. The FSM stays in apb_cmd_master.

Test Plan:
- Write 0x00 data 0x1, PREADY=1 -> PSEL at N+1, PENABLE at N+2, PWRITE=1, PWDATA=0x1. rsp_valid at N+3, rsp_rdata=0, rsp_err=0.
- Read 0x08, slave returns 0x0000_1234 with PREADY low 3 cycles -> PENABLE held 4 cycles, addr stable. rsp_rdata=0x1234 at N+6.
- Poll 0x04, mask 0x1, limit 0, slave returns 0 for 3 reads then 1 -> 4 APB reads spaced POLL_GAP+2=6 cycles apart. rsp_rdata=1, rsp_timeout=0.
- Poll mask 0x1, limit 5, slave always 0 -> exactly 5 reads, then rsp_timeout=1, rsp_err=0.
- Read with PSLVERR=1 -> rsp_err=1. Reserved op 11 -> rsp_err=1 at N+1, PSEL never asserted.
- RESETN low during ACCESS of a poll -> PSEL/PENABLE 0 asynchronously, rsp_valid=0, cmd_ready=1 after release. rsp_ready held low 10 cycles in RESP -> outputs stable, no new bus cycle.
